// File: rtl/dac_data_adapter.sv
// dac_data_adapter
// Consumes a 128-bit AXI-Stream of sample pairs and drives two 14-bit DAC
// lanes for a programmed number of beats after a start trigger. Outside a
// burst both lanes are parked at IDLE_CODE. Cycles in PLAY with no data
// available are counted as underruns (saturating).

module dac_data_adapter #(
    parameter logic [13:0] IDLE_CODE = 14'h2000
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic [31:0]  sample_count,
    input  logic         start_trigger,
    output logic         start_trigger_ack,
    output logic [31:0]  sample_counter,
    output logic [1:0]   sample_state,
    output logic [15:0]  underrun_count,
    output logic [13:0]  dac_data_1,
    output logic [13:0]  dac_data_2,
    output logic         dac_valid,
    input  logic [127:0] s_axis_tdata,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2,
        ST_RSVD = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] counter_r;
    logic [31:0] counter_next_s;
    logic        ack_r;
    logic        ack_next_s;
    logic [15:0] underrun_r;
    logic [15:0] underrun_next_s;
    logic [13:0] data1_r;
    logic [13:0] data1_next_s;
    logic [13:0] data2_r;
    logic [13:0] data2_next_s;
    logic        valid_r;
    logic        valid_next_s;
    logic        tready_s;
    logic        xfer_s;

    // Only lane bits [13:0] and [77:64] carry samples; the rest is don't-care.
    logic        unused_tdata_s;
    assign unused_tdata_s = ^{s_axis_tdata[127:78], s_axis_tdata[63:14]};

    // Ready depends on the state register alone so reset drops it at once.
    assign tready_s = (state_r == ST_PLAY);
    assign xfer_s   = s_axis_tvalid & tready_s;

    // Next-state and next-output decode for every registered output.
    always_comb begin
        state_next_s    = state_r;
        counter_next_s  = counter_r;
        ack_next_s      = 1'b0;
        underrun_next_s = underrun_r;
        data1_next_s    = data1_r;
        data2_next_s    = data2_r;
        valid_next_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                counter_next_s = sample_count;
                data1_next_s   = IDLE_CODE;
                data2_next_s   = IDLE_CODE;
                if (start_trigger) begin
                    ack_next_s      = 1'b1;
                    underrun_next_s = 16'h0000;
                    if (sample_count != 32'd0) begin
                        state_next_s = ST_PLAY;
                    end else begin
                        // Zero-length burst: no beats, straight to DONE.
                        state_next_s = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (xfer_s) begin
                    data1_next_s   = s_axis_tdata[13:0];
                    data2_next_s   = s_axis_tdata[77:64];
                    valid_next_s   = 1'b1;
                    counter_next_s = counter_r - 32'd1;
                    if (counter_r == 32'd1) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_PLAY;
                    end
                end else begin
                    // Underrun: hold the lanes, count the starved cycle.
                    if (underrun_r != 16'hFFFF) begin
                        underrun_next_s = underrun_r + 16'd1;
                    end else begin
                        underrun_next_s = underrun_r;
                    end
                end
            end
            ST_DONE: begin
                data1_next_s = IDLE_CODE;
                data2_next_s = IDLE_CODE;
                state_next_s = ST_IDLE;
            end
            default: begin
                data1_next_s   = IDLE_CODE;
                data2_next_s   = IDLE_CODE;
                counter_next_s = 32'd0;
                state_next_s   = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous return to idle values.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r    <= ST_IDLE;
            counter_r  <= 32'd0;
            ack_r      <= 1'b0;
            underrun_r <= 16'h0000;
            data1_r    <= IDLE_CODE;
            data2_r    <= IDLE_CODE;
            valid_r    <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            counter_r  <= counter_next_s;
            ack_r      <= ack_next_s;
            underrun_r <= underrun_next_s;
            data1_r    <= data1_next_s;
            data2_r    <= data2_next_s;
            valid_r    <= valid_next_s;
        end
    end

    assign s_axis_tready     = tready_s;
    assign sample_state      = state_r;
    assign sample_counter    = counter_r;
    assign start_trigger_ack = ack_r;
    assign underrun_count    = underrun_r;
    assign dac_data_1        = data1_r;
    assign dac_data_2        = data2_r;
    assign dac_valid         = valid_r;

endmodule

// File: tb/tb_dac_data_adapter.sv
// Directed self-checking bench for dac_data_adapter.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. they show the values for the cycle following that edge.

module tb_dac_data_adapter;

    logic         aclk;
    logic         areset;
    logic [31:0]  sample_count;
    logic         start_trigger;
    logic         start_trigger_ack;
    logic [31:0]  sample_counter;
    logic [1:0]   sample_state;
    logic [15:0]  underrun_count;
    logic [13:0]  dac_data_1;
    logic [13:0]  dac_data_2;
    logic         dac_valid;
    logic [127:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;

    int n_cmp;
    int n_fail;

    // Packed view: {state, tready, valid, ack, lane1, lane2}
    logic [32:0] obs;
    assign obs = {sample_state, s_axis_tready, dac_valid, start_trigger_ack,
                  dac_data_1, dac_data_2};

    dac_data_adapter dut (
        .aclk              (aclk),
        .areset            (areset),
        .sample_count      (sample_count),
        .start_trigger     (start_trigger),
        .start_trigger_ack (start_trigger_ack),
        .sample_counter    (sample_counter),
        .sample_state      (sample_state),
        .underrun_count    (underrun_count),
        .dac_data_1        (dac_data_1),
        .dac_data_2        (dac_data_2),
        .dac_valid         (dac_valid),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Beat with all non-lane bits set, to show they are ignored.
    function automatic logic [127:0] beat(input logic [13:0] l1, input logic [13:0] l2);
        logic [127:0] t;
        t = '1;
        t[13:0]  = l1;
        t[77:64] = l2;
        return t;
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        logic [32:0] exp;
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        exp = {2'd0, 1'b0, 1'b0, 1'b0, 14'h2000, 14'h2000};
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", obs, exp);
        end
        n_cmp++;
        if (sample_counter !== 32'd0 || underrun_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got cnt=%0d und=%0d want 0/0", sample_counter, underrun_count);
        end
        areset = 1'b0;
    endtask

    task automatic test_basic();
        logic [32:0] exp;
        sample_count  = 32'd4;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = beat(14'h0001, 14'h1001);
        start_trigger = 1'b1;
        step();
        start_trigger = 1'b0;
        exp = {2'd1, 1'b1, 1'b0, 1'b1, 14'h2000, 14'h2000};
        n_cmp++;
        if (obs !== exp || sample_counter !== 32'd4) begin
            n_fail++;
            $display("FAIL basic_trigger: got %h cnt=%0d want %h cnt=4", obs, sample_counter, exp);
        end
        for (int i = 1; i <= 4; i++) begin
            s_axis_tdata = beat(14'(i), 14'(32'h1000 + i));
            step();
            exp = {(i == 4) ? 2'd2 : 2'd1, (i == 4) ? 1'b0 : 1'b1, 1'b1, 1'b0,
                   14'(i), 14'(32'h1000 + i)};
            n_cmp++;
            if (obs !== exp || sample_counter !== 32'(4 - i)) begin
                n_fail++;
                $display("FAIL basic_beat%0d: got %h cnt=%0d want %h cnt=%0d",
                         i, obs, sample_counter, exp, 4 - i);
            end
        end
        s_axis_tdata = beat(14'h0005, 14'h1005);
        step();
        exp = {2'd0, 1'b0, 1'b0, 1'b0, 14'h2000, 14'h2000};
        n_cmp++;
        if (obs !== exp || underrun_count !== 16'd0) begin
            n_fail++;
            $display("FAIL basic_idle: got %h und=%0d want %h und=0", obs, underrun_count, exp);
        end
        step();
        n_cmp++;
        if (sample_counter !== 32'd4 || obs !== exp) begin
            n_fail++;
            $display("FAIL basic_reload: got cnt=%0d obs=%h want cnt=4 obs=%h", sample_counter, obs, exp);
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic test_underrun();
        logic [32:0] exp;
        sample_count  = 32'd3;
        start_trigger = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = beat(14'h0111, 14'h0222);
        step();
        start_trigger = 1'b0;
        step();
        exp = {2'd1, 1'b1, 1'b1, 1'b0, 14'h0111, 14'h0222};
        n_cmp++;
        if (obs !== exp || sample_counter !== 32'd2) begin
            n_fail++;
            $display("FAIL under_beat1: got %h cnt=%0d want %h cnt=2", obs, sample_counter, exp);
        end
        s_axis_tvalid = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            step();
            exp = {2'd1, 1'b1, 1'b0, 1'b0, 14'h0111, 14'h0222};
            n_cmp++;
            if (obs !== exp || underrun_count !== 16'(i) || sample_counter !== 32'd2) begin
                n_fail++;
                $display("FAIL under_gap%0d: got %h und=%0d cnt=%0d want %h und=%0d cnt=2",
                         i, obs, underrun_count, sample_counter, exp, i);
            end
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = beat(14'h0333, 14'h0444);
        step();
        s_axis_tdata  = beat(14'h0555, 14'h0666);
        exp = {2'd1, 1'b1, 1'b1, 1'b0, 14'h0333, 14'h0444};
        n_cmp++;
        if (obs !== exp || sample_counter !== 32'd1) begin
            n_fail++;
            $display("FAIL under_beat2: got %h cnt=%0d want %h cnt=1", obs, sample_counter, exp);
        end
        step();
        exp = {2'd2, 1'b0, 1'b1, 1'b0, 14'h0555, 14'h0666};
        n_cmp++;
        if (obs !== exp || sample_counter !== 32'd0 || underrun_count !== 16'd2) begin
            n_fail++;
            $display("FAIL under_beat3: got %h cnt=%0d und=%0d want %h cnt=0 und=2",
                     obs, sample_counter, underrun_count, exp);
        end
        step();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic test_zero_length();
        logic [32:0] exp;
        sample_count  = 32'd0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = beat(14'h0ABC, 14'h0DEF);
        start_trigger = 1'b1;
        step();
        start_trigger = 1'b0;
        exp = {2'd2, 1'b0, 1'b0, 1'b1, 14'h2000, 14'h2000};
        n_cmp++;
        if (obs !== exp || underrun_count !== 16'd0) begin
            n_fail++;
            $display("FAIL zero_done: got %h und=%0d want %h und=0", obs, underrun_count, exp);
        end
        step();
        exp = {2'd0, 1'b0, 1'b0, 1'b0, 14'h2000, 14'h2000};
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL zero_idle: got %h want %h", obs, exp);
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp;
        sample_count  = 32'd2;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = beat(14'h0010, 14'h0020);
        start_trigger = 1'b1;
        step();
        exp = {2'd1, 1'b1, 1'b0, 1'b1, 14'h2000, 14'h2000};
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL b2b_ack1: got %h want %h", obs, exp);
        end
        step();
        s_axis_tdata = beat(14'h0011, 14'h0021);
        exp = {2'd1, 1'b1, 1'b1, 1'b0, 14'h0010, 14'h0020};
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL b2b_beat1: got %h want %h", obs, exp);
        end
        step();
        exp = {2'd2, 1'b0, 1'b1, 1'b0, 14'h0011, 14'h0021};
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL b2b_beat2: got %h want %h", obs, exp);
        end
        step();
        s_axis_tdata = beat(14'h0012, 14'h0022);
        exp = {2'd0, 1'b0, 1'b0, 1'b0, 14'h2000, 14'h2000};
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL b2b_idle: got %h want %h", obs, exp);
        end
        step();
        start_trigger = 1'b0;
        exp = {2'd1, 1'b1, 1'b0, 1'b1, 14'h2000, 14'h2000};
        n_cmp++;
        if (obs !== exp || sample_counter !== 32'd2) begin
            n_fail++;
            $display("FAIL b2b_ack2: got %h cnt=%0d want %h cnt=2", obs, sample_counter, exp);
        end
        step();
        s_axis_tdata = beat(14'h0013, 14'h0023);
        exp = {2'd1, 1'b1, 1'b1, 1'b0, 14'h0012, 14'h0022};
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL b2b_beat3: got %h want %h", obs, exp);
        end
        step();
        step();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [32:0] exp;
        sample_count  = 32'd10;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = beat(14'h0777, 14'h0888);
        start_trigger = 1'b1;
        step();
        start_trigger = 1'b0;
        repeat (3) step();
        #2;
        areset = 1'b1;
        #1;
        exp = {2'd0, 1'b0, 1'b0, 1'b0, 14'h2000, 14'h2000};
        n_cmp++;
        if (obs !== exp || sample_counter !== 32'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got %h cnt=%0d want %h cnt=0", obs, sample_counter, exp);
        end
        #2;
        areset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL rstmid_idle%0d: got %h want %h", i, obs, exp);
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic test_saturate();
        logic [32:0] exp;
        sample_count  = 32'd1;
        s_axis_tvalid = 1'b0;
        start_trigger = 1'b1;
        step();
        start_trigger = 1'b0;
        for (int i = 0; i < 65534; i++) step();
        n_cmp++;
        if (underrun_count !== 16'hFFFE || sample_counter !== 32'd1) begin
            n_fail++;
            $display("FAIL sat_fffe: got und=%h cnt=%0d want und=fffe cnt=1", underrun_count, sample_counter);
        end
        step();
        n_cmp++;
        if (underrun_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_ffff: got %h want ffff", underrun_count);
        end
        step();
        n_cmp++;
        if (underrun_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_hold: got %h want ffff", underrun_count);
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = beat(14'h3FFF, 14'h0000);
        step();
        exp = {2'd2, 1'b0, 1'b1, 1'b0, 14'h3FFF, 14'h0000};
        n_cmp++;
        if (obs !== exp || underrun_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_beat: got %h und=%h want %h und=ffff", obs, underrun_count, exp);
        end
        step();
        start_trigger = 1'b1;
        step();
        start_trigger = 1'b0;
        exp = {2'd1, 1'b1, 1'b0, 1'b1, 14'h2000, 14'h2000};
        n_cmp++;
        if (obs !== exp || underrun_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL sat_clear: got %h und=%h want %h und=0", obs, underrun_count, exp);
        end
        step();
        step();
        s_axis_tvalid = 1'b0;
    endtask

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        areset        = 1'b1;
        sample_count  = 32'd0;
        start_trigger = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        test_reset();
        step();
        test_basic();
        test_underrun();
        test_zero_length();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
